ldtu_frame_builder: RTL

LDTU_FRAME_BUILDER -- requirements
Module: ldtu_frame_builder

---
 rtl/ldtu_pkg.sv | 29 ++
 rtl/ldtu_crc12.sv | 26 ++
 rtl/ldtu_frame_builder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ldtu_pkg.sv
// rtl/ldtu_pkg.sv - LiteDTU frame builder constants, sample-type codes and state type
package ldtu_pkg;

  localparam logic [3:0]  LDTU_TRAILER_ID = 4'b1101;
  localparam logic [31:0] LDTU_INITIAL    = 32'hF000_0000;
  localparam int          LDTU_CRC_W      = 12;

  // Sample-type codes carried in DATA_32[31:24]
  localparam logic [1:0] LDTU_CODE_SIG5  = 2'b01;
  localparam logic [1:0] LDTU_CODE_BASEN = 2'b10;
  localparam logic [1:0] LDTU_CODE_FLAG  = 2'b11;
  localparam logic [5:0] LDTU_CODE_SIG2  = 6'b001010;

  typedef enum logic {
    FILL  = 1'b0,
    TRAIL = 1'b1
  } ldtu_state_e;

  function automatic logic [7:0] ldtu_sumval(input logic [7:0] code);
    logic [7:0] n;
    if (code[7:6] == LDTU_CODE_SIG5)       n = 8'd5;
    else if (code[7:6] == LDTU_CODE_BASEN) n = {2'b00, code[5:0]};
    else if (code[7:6] == LDTU_CODE_FLAG)  n = 8'd0;
    else if (code[7:2] == LDTU_CODE_SIG2)  n = 8'd2;
    else                                   n = 8'd1;
    return n;
  endfunction

endpackage

// File: rtl/ldtu_crc12.sv
// rtl/ldtu_crc12.sv - LiteDTU parallel CRC-12 over one 32-bit word, MSB first
module ldtu_crc12
  import ldtu_pkg::*;
(
  input  logic [31:0]           data,
  input  logic [LDTU_CRC_W-1:0] crc,
  output logic [LDTU_CRC_W-1:0] newcrc
);

  localparam logic [LDTU_CRC_W-1:0] POLY = 12'h80F;

  logic [LDTU_CRC_W-1:0] c;
  logic                  fb;

  // Unrolled LFSR: the loop flattens into the per-bit XOR equations
  always_comb begin
    c  = crc;
    fb = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      fb = c[LDTU_CRC_W-1] ^ data[i];
      c  = {c[LDTU_CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    newcrc = c;
  end

endmodule

// File: rtl/ldtu_frame_builder.sv
// rtl/ldtu_frame_builder.sv - LiteDTU frame builder; optional idle timeout under LDTU_FRAME_TIMEOUT_EN
module ldtu_frame_builder
  import ldtu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FRAME_WORDS = 50,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              Load_data,
  input  logic [DATA_W-1:0] DATA_32,
  input  logic              full,
  input  logic              handshake,
  output logic [DATA_W-1:0] DATA_from_CU,
  output logic              write_signal,
  output logic              losing_data,
  output logic [15:0]       lost_count,
  output logic              frame_done,
  output logic              read_signal
);

  if (DATA_W < 32 || FRAME_WORDS < 1 || FRAME_WORDS > 255 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("ldtu_frame_builder: parameter out of range");
  end

  ldtu_state_e           state, state_nxt;
  logic [7:0]            wcount, wcount_nxt;
  logic [7:0]            nsamp, nsamp_nxt;
  logic [7:0]            nframe, nframe_nxt;
  logic [LDTU_CRC_W-1:0] crc, crc_nxt, crc_upd;
  logic [DATA_W-1:0]     data_nxt;
  logic                  write_nxt, done_nxt;
  logic [15:0]           lost_nxt;
  logic                  accept, drop, word_last, timeout_hit;

  ldtu_crc12 u_crc (
    .data   (DATA_32[31:0]),
    .crc    (crc),
    .newcrc (crc_upd)
  );

  assign accept    = (state == FILL) && Load_data && !full;
  assign drop      = Load_data && (full || state == TRAIL);
  assign word_last = accept && (wcount + 8'd1 == 8'(FRAME_WORDS));

`ifdef LDTU_FRAME_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        idle_cyc;

  assign idle_cyc    = (state == FILL) && !accept && (wcount != 8'd0) &&
                       (wcount < 8'(FRAME_WORDS));
  assign timeout_hit = idle_cyc && (idle_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (reset || !idle_cyc || timeout_hit) idle_cnt <= '0;
    else                                   idle_cnt <= idle_cnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (word_last || timeout_hit) state_nxt = TRAIL;
      TRAIL:   if (!full)                    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    data_nxt   = DATA_from_CU;
    write_nxt  = 1'b0;
    done_nxt   = 1'b0;
    wcount_nxt = wcount;
    nsamp_nxt  = nsamp;
    crc_nxt    = crc;
    nframe_nxt = nframe;
    lost_nxt   = (drop && lost_count != 16'hFFFF) ? lost_count + 16'd1 : lost_count;
    case (state)
      FILL: begin
        if (accept) begin
          data_nxt   = DATA_32;
          write_nxt  = 1'b1;
          wcount_nxt = wcount + 8'd1;
          nsamp_nxt  = nsamp + ldtu_sumval(DATA_32[31:24]);
          crc_nxt    = crc_upd;
        end
      end
      TRAIL: begin
        if (!full) begin
          data_nxt   = DATA_W'({LDTU_TRAILER_ID, nsamp, crc, nframe});
          write_nxt  = 1'b1;
          done_nxt   = 1'b1;
          wcount_nxt = '0;
          nsamp_nxt  = '0;
          crc_nxt    = '0;
          nframe_nxt = nframe + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      DATA_from_CU <= DATA_W'(LDTU_INITIAL);
      write_signal <= 1'b0;
      losing_data  <= 1'b0;
      lost_count   <= '0;
      frame_done   <= 1'b0;
      read_signal  <= 1'b0;
      wcount       <= '0;
      nsamp        <= '0;
      crc          <= '0;
      nframe       <= '0;
    end else begin
      DATA_from_CU <= data_nxt;
      write_signal <= write_nxt;
      losing_data  <= drop;
      lost_count   <= lost_nxt;
      frame_done   <= done_nxt;
      read_signal  <= handshake;
      wcount       <= wcount_nxt;
      nsamp        <= nsamp_nxt;
      crc          <= crc_nxt;
      nframe       <= nframe_nxt;
    end
  end

endmodule
